// File: rtl/tooth_scheduler_pkg.sv
// Shared types and helpers for the angle-domain tooth scheduler.
package tooth_scheduler_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WAIT = 2'd1,
    CH_ON   = 2'd2
  } ch_state_e;

  typedef enum logic {
    SC_IDLE = 1'b0,
    SC_SCAN = 1'b1
  } scan_state_e;

  localparam int unsigned FRAC_BITS_DEF = 8;
  // Product of a 32-bit period and a fraction of up to 16 bits.
  localparam int unsigned PROD_W = 48;

  // Integer part of period*frac, i.e. bits [31+FRAC_BITS:FRAC_BITS].
  function automatic logic [31:0] delay_slice(input logic [PROD_W-1:0] prod,
                                              input int unsigned frac_bits);
    return 32'(prod >> frac_bits);
  endfunction

endpackage

// File: rtl/tooth_scheduler_channel.sv
// One output channel: config registers, delay/dwell down-counter, channel FSM.
module sched_channel
  import tooth_scheduler_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 cfg_wr,
  input  logic                 cfg_en,
  input  logic [7:0]           cfg_tooth,
  input  logic [FRAC_BITS-1:0] cfg_frac,
  input  logic [31:0]          cfg_dwell,
  input  logic                 start,
  input  logic [31:0]          delay,
  output logic                 en_o,
  output logic [7:0]           tooth_o,
  output logic [FRAC_BITS-1:0] frac_o,
  output logic                 active_o,
  output logic                 out
);

  ch_state_e             state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           pend_q, pend_d;
  logic [31:0]           dwell_q, dwell_d;
  logic                  en_q, en_d;
  logic [7:0]            tooth_q, tooth_d;
  logic [FRAC_BITS-1:0]  frac_q, frac_d;
  logic                  out_q, out_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    en_d    = en_q;
    tooth_d = tooth_q;
    frac_d  = frac_q;
    dwell_d = dwell_q;

    if (cfg_wr) begin
      en_d    = cfg_en;
      tooth_d = cfg_tooth;
      frac_d  = cfg_frac;
      dwell_d = cfg_dwell;
    end

    // Dwell is captured at start so a config rewrite cannot reshape a pending pulse.
    unique case (state_q)
      CH_IDLE: begin
        if (start) begin
          state_d = CH_WAIT;
          cnt_d   = delay;
          pend_d  = dwell_q;
        end
      end
      CH_WAIT: begin
        if (cnt_q == '0) begin
          if (pend_q != '0) begin
            state_d = CH_ON;
            cnt_d   = pend_q - 32'd1;
          end else begin
            state_d = CH_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      CH_ON: begin
        if (cnt_q == '0) state_d = CH_IDLE;
        else             cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = CH_IDLE;
    endcase

    if (flush || (cfg_wr && !cfg_en)) state_d = CH_IDLE;

    out_d = (state_d == CH_ON);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      en_q    <= 1'b0;
      tooth_q <= '0;
      frac_q  <= '0;
      dwell_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      tooth_q <= tooth_d;
      frac_q  <= frac_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
    end
  end

  assign en_o     = en_q;
  assign tooth_o  = tooth_q;
  assign frac_o   = frac_q;
  assign active_o = (state_q != CH_IDLE);
  assign out      = out_q;

endmodule

// File: rtl/tooth_scheduler.sv
// Tooth-triggered output scheduler: scan FSM, shared delay multiplier, error flags.
module tooth_scheduler
  import tooth_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      trigger,
  input  logic                      synced,
  input  logic [7:0]                tooth_num,
  input  logic [31:0]               tooth_period,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic                      cfg_en,
  input  logic [7:0]                cfg_tooth,
  input  logic [FRAC_BITS-1:0]      cfg_frac,
  input  logic [31:0]               cfg_dwell,
  input  logic                      clr_err,
  output logic [NUM_CH-1:0]         out,
  output logic                      busy,
  output logic                      err_overrun,
  output logic                      err_scan
);

  localparam int unsigned CW = $clog2(NUM_CH);

  scan_state_e          scan_q, scan_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [7:0]           tooth_q, tooth_d;
  logic [31:0]          period_q, period_d;
  logic                 err_ov_q, err_ov_d;
  logic                 err_sc_q, err_sc_d;

  logic [NUM_CH-1:0]    cfg_wr, ch_en, ch_active, start;
  logic [7:0]           ch_tooth [NUM_CH];
  logic [FRAC_BITS-1:0] ch_frac  [NUM_CH];
  logic [PROD_W-1:0]    prod;
  logic [31:0]          delay;
  logic                 match, trig_ok;

  always_comb begin
    scan_d   = scan_q;
    idx_d    = idx_q;
    tooth_d  = tooth_q;
    period_d = period_q;
    start    = '0;

    trig_ok = trigger && synced;
    match   = (scan_q == SC_SCAN) && synced && ch_en[idx_q] && (ch_tooth[idx_q] == tooth_q);
    prod    = PROD_W'(period_q) * PROD_W'(ch_frac[idx_q]);
    delay   = delay_slice(prod, FRAC_BITS);

    if (match && !ch_active[idx_q]) start[idx_q] = 1'b1;

    err_ov_d = (err_ov_q && !clr_err) || (match && ch_active[idx_q]);
    err_sc_d = (err_sc_q && !clr_err) || (trig_ok && scan_q == SC_SCAN);

    unique case (scan_q)
      SC_IDLE: begin
        if (trig_ok) begin
          scan_d   = SC_SCAN;
          idx_d    = '0;
          tooth_d  = tooth_num;
          period_d = tooth_period;
        end
      end
      SC_SCAN: begin
        if (idx_q == CW'(NUM_CH - 1)) scan_d = SC_IDLE;
        else                          idx_d  = idx_q + CW'(1);
      end
      default: scan_d = SC_IDLE;
    endcase

    if (!synced) scan_d = SC_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q   <= SC_IDLE;
      idx_q    <= '0;
      tooth_q  <= '0;
      period_q <= '0;
      err_ov_q <= 1'b0;
      err_sc_q <= 1'b0;
    end else begin
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      tooth_q  <= tooth_d;
      period_q <= period_d;
      err_ov_q <= err_ov_d;
      err_sc_q <= err_sc_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign cfg_wr[g] = cfg_we && (cfg_ch == CW'(g));

    sched_channel #(.FRAC_BITS(FRAC_BITS)) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (!synced),
      .cfg_wr    (cfg_wr[g]),
      .cfg_en    (cfg_en),
      .cfg_tooth (cfg_tooth),
      .cfg_frac  (cfg_frac),
      .cfg_dwell (cfg_dwell),
      .start     (start[g]),
      .delay     (delay),
      .en_o      (ch_en[g]),
      .tooth_o   (ch_tooth[g]),
      .frac_o    (ch_frac[g]),
      .active_o  (ch_active[g]),
      .out       (out[g])
    );
  end

  assign busy        = (scan_q == SC_SCAN);
  assign err_overrun = err_ov_q;
  assign err_scan    = err_sc_q;

endmodule

// File: tb/tb_tooth_scheduler.sv
// Bench for tooth_scheduler: timeline model of pulse windows checked every cycle.
module tb_tooth_scheduler;
  localparam int NCH = 4;
  localparam int FB  = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            trigger, synced, cfg_we, cfg_en, clr_err;
  logic [7:0]      tooth_num, cfg_tooth;
  logic [31:0]     tooth_period, cfg_dwell;
  logic [1:0]      cfg_ch;
  logic [FB-1:0]   cfg_frac;
  logic [NCH-1:0]  out;
  logic            busy, err_overrun, err_scan;

  tooth_scheduler #(.NUM_CH(NCH), .FRAC_BITS(FB)) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .synced(synced),
    .tooth_num(tooth_num), .tooth_period(tooth_period), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_tooth(cfg_tooth), .cfg_frac(cfg_frac),
    .cfg_dwell(cfg_dwell), .clr_err(clr_err), .out(out), .busy(busy),
    .err_overrun(err_overrun), .err_scan(err_scan)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  longint edge_n = 0;

  // Model: config shadow, plus per channel the edge its output rises and the
  // edge from which it is idle again; output is high after edges in [rise, idle).
  logic        m_en    [NCH];
  logic [7:0]  m_tooth [NCH];
  logic [7:0]  m_frac  [NCH];
  logic [31:0] m_dwell [NCH];
  longint      m_rise  [NCH];
  longint      m_idle  [NCH];
  longint      m_scan_s;
  logic [7:0]  m_lt;
  logic [31:0] m_lp;
  logic        m_ov, m_sc;

  longint first_rise [NCH];
  int     hi_cnt     [NCH];
  int     busy_cnt;

  function automatic logic [NCH+2:0] exp_vec();
    logic [NCH-1:0] o;
    logic b;
    for (int k = 0; k < NCH; k++) o[k] = (m_rise[k] <= edge_n) && (edge_n < m_idle[k]);
    b = (m_scan_s >= 0) && (edge_n <= m_scan_s + NCH - 1);
    return {o, b, m_ov, m_sc};
  endfunction

  function automatic logic [NCH+2:0] obs();
    return {out, busy, err_overrun, err_scan};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_en[k] = 1'b0; m_tooth[k] = '0; m_frac[k] = '0; m_dwell[k] = '0;
      m_rise[k] = 0; m_idle[k] = 0;
    end
    m_scan_s = -1; m_lt = '0; m_lp = '0; m_ov = 1'b0; m_sc = 1'b0;
  endtask

  task automatic clear_obs();
    for (int k = 0; k < NCH; k++) begin first_rise[k] = -1; hi_cnt[k] = 0; end
    busy_cnt = 0;
  endtask

  // Advances the model across the next edge using the currently driven inputs,
  // then takes that edge and clears the single-cycle strobes.
  task automatic tick();
    longint n;
    logic   busy_pre, ov_set, sc_set;
    int     k;
    longint d;
    n        = edge_n + 1;
    busy_pre = (m_scan_s >= 0) && (n - 1 <= m_scan_s + NCH - 1);
    ov_set   = 1'b0;
    sc_set   = 1'b0;
    if (busy_pre && synced) begin
      k = int'(n - 1 - m_scan_s);
      if (m_en[k] && m_tooth[k] == m_lt) begin
        if (m_idle[k] <= n - 1) begin
          d = (longint'(m_lp) * longint'(m_frac[k])) / 256;
          m_rise[k] = n + 1 + d;
          m_idle[k] = m_rise[k] + longint'(m_dwell[k]);
        end else begin
          ov_set = 1'b1;
        end
      end
      if (k == NCH - 1) m_scan_s = -1;
    end
    if (trigger && synced) begin
      if (busy_pre) sc_set = 1'b1;
      else begin m_scan_s = n; m_lt = tooth_num; m_lp = tooth_period; end
    end
    if (!synced) begin
      m_scan_s = -1;
      for (int j = 0; j < NCH; j++) if (m_idle[j] > n) m_idle[j] = n;
    end
    if (cfg_we) begin
      if (!cfg_en && m_idle[cfg_ch] > n) m_idle[cfg_ch] = n;
      m_en[cfg_ch] = cfg_en; m_tooth[cfg_ch] = cfg_tooth;
      m_frac[cfg_ch] = cfg_frac; m_dwell[cfg_ch] = cfg_dwell;
    end
    m_ov = ov_set | (m_ov & ~clr_err);
    m_sc = sc_set | (m_sc & ~clr_err);
    @(posedge clk);
    #1;
    edge_n = n;
    trigger = 1'b0; cfg_we = 1'b0; clr_err = 1'b0;
    for (int j = 0; j < NCH; j++) if (out[j]) begin
      hi_cnt[j]++;
      if (first_rise[j] < 0) first_rise[j] = edge_n;
    end
    if (busy) busy_cnt++;
  endtask

  task automatic set_cfg(input int ch, input logic en, input int tooth, input int frac, input int dwell);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_en = en;
    cfg_tooth = 8'(tooth); cfg_frac = FB'(frac); cfg_dwell = 32'(dwell);
  endtask

  task automatic set_trig(input int tooth, input int period);
    trigger = 1'b1; tooth_num = 8'(tooth); tooth_period = 32'(period);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs() !== exp_vec()) begin bad++; $display("FAIL reset_async got=%b exp=%b", obs(), exp_vec()); end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
  endtask

  task automatic test_basic();
    longint t0;
    set_cfg(0, 1, 5, 128, 10);
    tick();
    clear_obs();
    set_trig(5, 1000);
    t0 = edge_n + 1;
    repeat (530) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL basic cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (first_rise[0] !== t0 + 502) begin bad++; $display("FAIL basic_rise got=%0d exp=%0d", first_rise[0], t0 + 502); end
    total++;
    if (hi_cnt[0] !== 10) begin bad++; $display("FAIL basic_width got=%0d exp=10", hi_cnt[0]); end
    clear_obs();
    set_trig(4, 1000);
    repeat (530) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL wrong_tooth cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (hi_cnt[0] !== 0) begin bad++; $display("FAIL wrong_tooth_pulse got=%0d exp=0", hi_cnt[0]); end
  endtask

  task automatic test_two_ch();
    longint t0;
    set_cfg(1, 1, 3, 0, 1);   tick();
    set_cfg(2, 1, 3, 255, 20); tick();
    clear_obs();
    set_trig(3, 256);
    t0 = edge_n + 1;
    repeat (300) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL two_ch cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (first_rise[1] !== t0 + 3 || hi_cnt[1] !== 1) begin
      bad++; $display("FAIL two_ch_ch1 rise=%0d width=%0d exp rise=%0d width=1", first_rise[1], hi_cnt[1], t0 + 3);
    end
    total++;
    if (first_rise[2] !== t0 + 259 || hi_cnt[2] !== 20) begin
      bad++; $display("FAIL two_ch_ch2 rise=%0d width=%0d exp rise=%0d width=20", first_rise[2], hi_cnt[2], t0 + 259);
    end
    total++;
    if (busy_cnt !== NCH) begin bad++; $display("FAIL two_ch_busy got=%0d exp=%0d", busy_cnt, NCH); end
  endtask

  task automatic test_overrun();
    longint t0;
    set_cfg(0, 1, 5, 128, 5000); tick();
    clear_obs();
    set_trig(5, 1000);
    t0 = edge_n + 1;
    for (int c = 0; c < 5600; c++) begin
      if (c == 1000) set_trig(5, 1000);
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL overrun cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (err_overrun !== 1'b1 || first_rise[0] !== t0 + 502 || hi_cnt[0] !== 5000) begin
      bad++; $display("FAIL overrun_flag err=%b rise=%0d width=%0d exp err=1 rise=%0d width=5000", err_overrun, first_rise[0], hi_cnt[0], t0 + 502);
    end
    clr_err = 1'b1;
    tick(); total++;
    if (err_overrun !== 1'b0 || obs() !== exp_vec()) begin bad++; $display("FAIL overrun_clear got=%b exp=%b", obs(), exp_vec()); end
  endtask

  task automatic test_sync_drop();
    set_cfg(3, 1, 7, 0, 100); tick();
    set_trig(7, 500);
    repeat (20) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL sync_pre cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    synced = 1'b0;
    tick(); total++;
    if (out[3] !== 1'b0 || obs() !== exp_vec()) begin bad++; $display("FAIL sync_drop got=%b exp=%b", obs(), exp_vec()); end
    clear_obs();
    for (int c = 0; c < 40; c++) begin
      if (c % 5 == 0) set_trig(7, 500);
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL sync_low cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (hi_cnt[3] !== 0 || busy_cnt !== 0) begin bad++; $display("FAIL sync_low_quiet hi=%0d busy=%0d exp 0 0", hi_cnt[3], busy_cnt); end
    synced = 1'b1;
  endtask

  task automatic test_back_to_back();
    clear_obs();
    for (int c = 0; c < 300; c++) begin
      if (c < 2) set_trig(3, 256);
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL b2b cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (err_scan !== 1'b1 || busy_cnt !== NCH || hi_cnt[1] !== 1 || hi_cnt[2] !== 20) begin
      bad++; $display("FAIL b2b_scan err=%b busy=%0d h1=%0d h2=%0d exp 1 %0d 1 20", err_scan, busy_cnt, hi_cnt[1], hi_cnt[2], NCH);
    end
    clr_err = 1'b1;
    tick(); total++;
    if (err_scan !== 1'b0) begin bad++; $display("FAIL b2b_clear got=%b exp=0", err_scan); end
  endtask

  task automatic test_dwell0_disable();
    set_cfg(3, 1, 11, 50, 0); tick();
    set_cfg(1, 1, 9, 200, 8); tick();
    clear_obs();
    set_trig(11, 100);
    repeat (60) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL dwell0 cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (hi_cnt[3] !== 0 || busy_cnt !== NCH) begin bad++; $display("FAIL dwell0_pulse hi=%0d busy=%0d exp 0 %0d", hi_cnt[3], busy_cnt, NCH); end
    clear_obs();
    set_trig(9, 400);
    for (int c = 0; c < 450; c++) begin
      if (c == 50) set_cfg(1, 0, 9, 200, 8);
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL disable cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (hi_cnt[1] !== 0) begin bad++; $display("FAIL disable_pulse got=%0d exp=0", hi_cnt[1]); end
  endtask

  task automatic test_random();
    int gap;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0)
        set_cfg(int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0, 20 + int'($urandom_range(0, 3)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 40)));
      set_trig(20 + int'($urandom_range(0, 3)), int'($urandom_range(8, 120)));
      if ($urandom_range(0, 9) == 0) clr_err = 1'b1;
      gap = int'($urandom_range(1, 140));
      for (int c = 0; c < gap; c++) begin
        synced = !(c == gap / 2 && $urandom_range(0, 9) == 0);
        if (c == gap / 3 && $urandom_range(0, 5) == 0)
          set_cfg(int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 20 + int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 40)));
        tick(); total++;
        if (obs() !== exp_vec()) begin bad++; $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, edge_n, obs(), exp_vec()); end
      end
    end
    synced = 1'b1;
    repeat (200) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL random_drain cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
  endtask

  task automatic test_async_reset();
    set_cfg(2, 1, 30, 0, 200); tick();
    set_trig(30, 50);
    repeat (20) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL areset_pre cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (out !== '0 || obs() !== exp_vec()) begin bad++; $display("FAIL areset_mid got=%b exp=%b", obs(), exp_vec()); end
    tick();
    reset_n = 1'b1;
    clear_obs();
    set_trig(30, 50);
    repeat (40) begin
      tick(); total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL areset_post cyc=%0d got=%b exp=%b", edge_n, obs(), exp_vec()); end
    end
    total++;
    if (hi_cnt[2] !== 0) begin bad++; $display("FAIL areset_cfg_cleared got=%0d exp=0", hi_cnt[2]); end
  endtask

  initial begin
    trigger = 1'b0; synced = 1'b1; tooth_num = '0; tooth_period = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_tooth = '0; cfg_frac = '0;
    cfg_dwell = '0; clr_err = 1'b0;
    model_reset();
    clear_obs();
    test_reset();
    test_basic();
    test_two_ch();
    test_overrun();
    test_sync_drop();
    test_back_to_back();
    test_dwell0_disable();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tooth_scheduler.md
# tooth_scheduler

Angle-domain output scheduler for the crank decoder. On each synced tooth trigger it scans its channels and, for every enabled channel programmed for the current tooth, starts an output pulse after a delay equal to a fraction of the measured tooth period. Pulse width is an absolute cycle count. The block sits between the tooth-sync decoder (trigger, tooth number, period, sync flag) and the injector/coil drivers. It is the single consumer and sequencer of that decoder's timing outputs.

## Interface
- NUM_CH, 4: number of output channels (2..8).
- FRAC_BITS, 8: width of the fractional tooth offset.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- trigger  in  1  one-cycle pulse per accepted tooth edge, from the decoder.
- synced  in  1  decoder sync status.
- tooth_num  in  8  current tooth index; valid in the trigger cycle.
- tooth_period  in  32  last tooth period in clk cycles; valid in the trigger cycle.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(NUM_CH)  channel addressed by the write.
- cfg_en  in  1  channel enable.
- cfg_tooth  in  8  tooth index on which the channel fires.
- cfg_frac  in  FRAC_BITS  offset into the tooth, in units of period/2^FRAC_BITS.
- cfg_dwell  in  32  pulse width in clk cycles.
- clr_err  in  1  clears the sticky error flags.
- out  out  NUM_CH  channel outputs, active high.
- busy  out  1  scan in progress.
- err_overrun  out  1  sticky: a channel matched while still WAIT/ON.
- err_scan  out  1  sticky: a trigger arrived while busy.

## Operation
- Config is held in per-channel registers and written in one cycle on cfg_we. A write to an active channel does not alter an in-flight delay or pulse. If the write sets cfg_en=0, the channel is forced to IDLE and its output goes low the next cycle.
- Scan FSM states:
  - IDLE: on trigger && synced, latch tooth_num and tooth_period, set busy, go to SCAN with index 0.
  - SCAN: evaluate one channel per cycle. When index NUM_CH-1 is done, return to IDLE.
- Channel k matches when cfg_en && cfg_tooth == latched tooth.
  - If the channel is IDLE: load delay = (period × cfg_frac) >> FRAC_BITS, using bits [31+FRAC_BITS:FRAC_BITS] of the 32+FRAC_BITS product. The result is always less than period, so no saturation is needed. The channel goes to WAIT.
  - If the channel is WAIT or ON: the event is ignored and err_overrun is set.
- A single multiplier is shared across all channels by the scan.
- Channel FSM:
  - WAIT: count down the delay. At 0, go to ON if dwell ≠ 0, otherwise return to IDLE with no pulse.
  - ON: out=1 for exactly dwell cycles, then go to IDLE.
- A trigger while busy is dropped and sets err_scan; the current scan completes.
- When synced goes low, all channels go to IDLE, out goes to 0 and the scan aborts to IDLE, all on the next clock edge. Triggers with synced=0 are ignored.
- clr_err clears both error flags. If an error event occurs in the same cycle, the set wins.

## Timing
- Reset values: out=0, busy=0, err_overrun=0, err_scan=0, all config registers 0 (channels disabled), all FSMs in IDLE.
- Trigger sampled at edge T. busy is high for cycles T+1 .. T+NUM_CH. Channel k is evaluated in cycle T+1+k.
- Channel k's out rises at edge T+2+k+delay and stays high for exactly dwell cycles.
- Back-to-back tooth events on a channel are legal if the previous pulse ends (out falls) before that channel's evaluation cycle.
- Config writes in the evaluation cycle of a channel are not seen by that evaluation; the registered old values are used.

## Structure
- Shared package/include holds: channel state encoding (IDLE/WAIT/ON), scan state encoding, FRAC_BITS default, and the delay-product slice helper.
- Sub-module sched_channel, instantiated NUM_CH times: config registers, delay/dwell down-counter, channel FSM, out flop.
- The top level holds the scan FSM, the latched tooth and period, the shared multiplier and the error flags.

## Test plan
- Ch0 {en, tooth 5, frac 128, dwell 10}, period 1000, trigger at tooth 5 in cycle T -> out[0] high from T+502 for exactly 10 cycles. Trigger at tooth 4 -> no pulse.
- Ch1 {en, tooth 3, frac 0, dwell 1} and ch2 {en, tooth 3, frac 255, dwell 20}, period 256, trigger at tooth 3 -> out[1] high at T+3 for 1 cycle, out[2] high at T+259 for 20 cycles, busy high T+1..T+4.
- Ch0 dwell 5000, period 1000, same tooth retriggered 1000 cycles later -> second event ignored, err_overrun=1, single pulse of 5000 cycles; clr_err -> 0.
- Pulse in progress on ch3, synced drops -> out[3]=0 next cycle, later triggers with synced=0 produce nothing.
- Second trigger one cycle after the first -> err_scan=1, first scan completes normally.
- Dwell 0 -> no output.
- Disable write during WAIT -> no pulse.
- reset_n asserted mid-pulse -> out=0 immediately (asynchronous).
